// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the two-requester UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int NREQ             = 2;
  localparam int LOCK_TIMEOUT_DEF = 4096;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/uart_tx_arb_rr_pick2.sv
// Two-way round-robin picker: on contention, favours the requester not served last.
module rr_pick2
  import uart_tx_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two byte streams onto one buffered UART, with per-message locking.
// state  | meaning
// IDLE   | grant selection, byte acceptance
// ISSUE  | one-cycle uart_wr strobe
// SETTLE | covers the UART's one-cycle busy latency
// DRAIN  | wait for uart_busy to drop
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             uart_wr,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_busy,
  output logic [1:0]       grant,
  output logic             locked,
  output logic [CNT_W-1:0] sent0,
  output logic [CNT_W-1:0] sent1
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [1:0]    state;
  logic          ptr;
  logic          cur;
  logic          pend_last;
  logic [TW-1:0] tmo;
  logic [1:0]    pick;
  logic [1:0]    owner;
  logic          accept;
  logic          acc_idx;
  logic          acc_last;
  logic [7:0]    acc_data;
  logic          tmo_run;
  logic          tmo_hit;

  rr_pick2 u_pick (
    .req   (req_valid),
    .last  (ptr),
    .grant (pick)
  );

  // Outside IDLE, or while locked, the grant is pinned to the current owner.
  always_comb begin
    owner     = cur ? 2'b10 : 2'b01;
    grant     = ((state != ST_IDLE) || locked) ? owner : pick;
    req_ready = 2'b00;
    if (state == ST_IDLE && !uart_busy)
      req_ready = grant & req_valid;
  end

  assign accept   = |req_ready;
  assign acc_idx  = req_ready[1];
  assign acc_last = acc_idx ? req_last[1] : req_last[0];
  assign acc_data = acc_idx ? req_data1 : req_data0;
  assign uart_wr  = (state == ST_ISSUE);
  assign tmo_run  = locked && (state == ST_IDLE) && !req_valid[cur];
  assign tmo_hit  = tmo_run && (tmo == TW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      uart_tx_data <= 8'h00;
      locked       <= 1'b0;
      ptr          <= 1'b0;
      cur          <= 1'b0;
      pend_last    <= 1'b0;
      tmo          <= '0;
      sent0        <= '0;
      sent1        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state        <= ST_ISSUE;
            uart_tx_data <= acc_data;
            cur          <= acc_idx;
            pend_last    <= acc_last;
            if (!acc_last)
              locked <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_SETTLE;
          if (cur)
            sent1 <= sent1 + 1'b1;
          else
            sent0 <= sent0 + 1'b1;
        end
        ST_SETTLE: state <= ST_DRAIN;
        default: begin
          if (!uart_busy) begin
            state <= ST_IDLE;
            if (pend_last) begin
              locked <= 1'b0;
              ptr    <= cur;
            end
          end
        end
      endcase

      // A stalled lock owner loses the lock after LOCK_TIMEOUT idle cycles.
      if (accept || !locked)
        tmo <= '0;
      else if (tmo_hit) begin
        tmo    <= '0;
        locked <= 1'b0;
        ptr    <= cur;
      end else if (tmo_run)
        tmo <= tmo + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small busy-UART model and byte monitor.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_data0, req_data1;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic       uart_wr;
  logic [7:0] uart_tx_data;
  logic       uart_busy;
  logic [1:0] grant;
  logic       locked;
  logic [3:0] sent0, sent1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_viol = 0;
  bit model_en = 1'b0;
  logic busy_force = 1'b0;

  logic [7:0] log_q[$];
  bit         lock_q[$];
  int         time_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  uart_tx_arb #(.LOCK_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_last(req_last), .req_ready(req_ready),
    .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
    .grant(grant), .locked(locked), .sent0(sent0), .sent1(sent1)
  );

  always #5 clk = ~clk;

  assign uart_busy = model_en ? (busy_cnt > 0) : busy_force;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_wr) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (!reset && uart_wr) begin
      log_q.push_back(uart_tx_data);
      lock_q.push_back(locked);
      time_q.push_back(cyc);
      if (uart_busy) busy_viol++;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; req_last = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
    model_en = 1'b0; busy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete(); lock_q.delete(); time_q.delete(); q0.delete(); q1.delete();
  endtask

  task automatic run(input int target, input int budget, input int start1, input int drain);
    int c = 0;
    logic [1:0] rdy;
    logic [8:0] tmp;
    while (log_q.size() < target && c < budget) begin
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0) && (c >= start1);
      if (q0.size() > 0) begin tmp = q0[0]; req_data0 = tmp[7:0]; req_last[0] = tmp[8]; end
      if (q1.size() > 0) begin tmp = q1[0]; req_data1 = tmp[7:0]; req_last[1] = tmp[8]; end
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy[0]) tmp = q0.pop_front();
      if (rdy[1]) tmp = q1.pop_front();
      c++;
    end
    req_valid = 2'b00;
    checks++;
    if (log_q.size() < target) begin
      errors++;
      $display("FAIL run_budget: got %0d bytes want %0d", log_q.size(), target);
    end
    repeat (drain) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_last = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
    reset = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", uart_wr); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", uart_tx_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (sent0 !== 4'd0 || sent1 !== 4'd0) begin errors++; $display("FAIL reset_sent: got %0d/%0d want 0/0", sent0, sent1); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h41; req_last = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_tx_data !== 8'h41) begin errors++; $display("FAIL single_wr: got wr=%b data=%h want wr=1 data=41", uart_wr, uart_tx_data); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_off: got %b want 00", req_ready); end
    @(negedge clk);
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL single_wr_once: got %b want 0", uart_wr); end
    checks++; if (sent0 !== 4'd1 || sent1 !== 4'd0) begin errors++; $display("FAIL single_sent: got %0d/%0d want 1/0", sent0, sent1); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    logic [7:0] exp [4];
    exp[0] = 8'hB1; exp[1] = 8'hA1; exp[2] = 8'hB2; exp[3] = 8'hA2;
    do_reset();
    q0.push_back(9'h1A1); q0.push_back(9'h1A2);
    q1.push_back(9'h1B1); q1.push_back(9'h1B2);
    run(4, 200, 0, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL contention_order[%0d]: got %h want %h", i, (log_q.size() > i) ? log_q[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp [3];
    bit         expl [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    expl[0] = 1'b1; expl[1] = 1'b1; expl[2] = 1'b0;
    do_reset();
    q0.push_back(9'h041); q0.push_back(9'h142);
    q1.push_back(9'h143);
    run(3, 200, 1, 5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp[i] || lock_q[i] !== expl[i]) begin
        errors++;
        $display("FAIL lock_seq[%0d]: got data=%h locked=%b want data=%h locked=%b", i,
                 (log_q.size() > i) ? log_q[i] : 8'hxx, (lock_q.size() > i) ? lock_q[i] : 1'b0, exp[i], expl[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h55; req_last = 2'b00;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tmo_accept: got %b want 01", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b10; req_data1 = 8'h66; req_last = 2'b10;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL tmo_wr_lock: got wr=%b locked=%b want 1/1", uart_wr, locked); end
    repeat (10) @(negedge clk);
    checks++; if (locked !== 1'b1 || grant !== 2'b01 || req_ready !== 2'b00) begin
      errors++; $display("FAIL tmo_before: got locked=%b grant=%b ready=%b want 1/01/00", locked, grant, req_ready); end
    @(negedge clk);
    checks++; if (locked !== 1'b0 || grant !== 2'b10 || req_ready !== 2'b10) begin
      errors++; $display("FAIL tmo_after: got locked=%b grant=%b ready=%b want 0/10/10", locked, grant, req_ready); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_tx_data !== 8'h66) begin errors++; $display("FAIL tmo_req1_wr: got wr=%b data=%h want 1/66", uart_wr, uart_tx_data); end
    checks++; if (sent0 !== 4'd1) begin errors++; $display("FAIL tmo_sent0: got %0d want 1", sent0); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_block();
    do_reset();
    busy_force = 1'b1;
    req_valid = 2'b01; req_data0 = 8'h5A; req_last = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || grant !== 2'b01) begin errors++; $display("FAIL busy_block: got ready=%b grant=%b want 00/01", req_ready, grant); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1 busy_force = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL withdraw_latched: got %0d bytes want 0", log_q.size()); end
    busy_force = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL busy_block2: got %b want 00", req_ready); end
    @(posedge clk); #1 busy_force = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL busy_release: got %b want 01", req_ready); end
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_tx_data !== 8'h5A) begin errors++; $display("FAIL busy_wr: got wr=%b data=%h want 1/5a", uart_wr, uart_tx_data); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_spacing();
    int min_gap = 1000;
    do_reset();
    model_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      q0.push_back(9'h100 | 9'(i));
      q1.push_back(9'h110 | 9'(i));
    end
    run(10, 400, 0, 25);
    checks++; if (log_q.size() != 10) begin errors++; $display("FAIL spacing_count: got %0d want 10", log_q.size()); end
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      logic [7:0] e;
      e = (i % 2 == 0) ? (8'h11 + 8'(i / 2)) : (8'h01 + 8'(i / 2));
      checks++; if (log_q[i] !== e) begin errors++; $display("FAIL spacing_order[%0d]: got %h want %h", i, log_q[i], e); end
    end
    for (int i = 1; i < time_q.size(); i++)
      if (time_q[i] - time_q[i-1] < min_gap) min_gap = time_q[i] - time_q[i-1];
    checks++; if (min_gap < 23) begin errors++; $display("FAIL spacing_gap: got %0d want >=23", min_gap); end
    checks++; if (busy_viol != 0) begin errors++; $display("FAIL spacing_wr_busy: got %0d want 0", busy_viol); end
    checks++; if (sent0 !== 4'd5 || sent1 !== 4'd5) begin errors++; $display("FAIL spacing_sent: got %0d/%0d want 5/5", sent0, sent1); end
    model_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) q0.push_back(9'h100 | 9'(i));
    run(17, 300, 0, 5);
    checks++; if (sent0 !== 4'd1 || sent1 !== 4'd0) begin errors++; $display("FAIL wrap_sent: got %0d/%0d want 1/0", sent0, sent1); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    model_en = 1'b1;
    q0.push_back(9'h177);
    run(1, 50, 0, 5);
    checks++; if (sent0 !== 4'd1) begin errors++; $display("FAIL mid_sent_pre: got %0d want 1", sent0); end
    #3 reset = 1'b1;
    #1;
    checks++; if (sent0 !== 4'd0 || uart_tx_data !== 8'h00 || locked !== 1'b0 || uart_wr !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got sent0=%0d data=%h locked=%b wr=%b want 0/00/0/0", sent0, uart_tx_data, locked, uart_wr); end
    n = log_q.size();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (log_q.size() != n) begin errors++; $display("FAIL mid_no_wr: got %0d bytes want %0d", log_q.size(), n); end
    q0.push_back(9'h199);
    run(n + 1, 100, 0, 25);
    checks++; if (log_q.size() <= n || log_q[n] !== 8'h99 || sent0 !== 4'd1) begin
      errors++; $display("FAIL mid_fresh: got data=%h sent0=%0d want 99/1", (log_q.size() > n) ? log_q[n] : 8'hxx, sent0); end
    model_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_busy_block();
    test_busy_spacing();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 4096: idle cycles a locked requester may stall before its lock is dropped.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-requester byte counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid, input, 2: per-requester byte-present flag.
REQ-006 SHALL have ports req_data0 and req_data1, input, 8 each: the requester bytes.
REQ-007 SHALL have ports req_last, input, 2: the offered byte ends the requester's message.
REQ-008 SHALL have ports req_ready, output, 2: the byte is accepted this cycle.
REQ-009 SHALL have port uart_wr, output, 1: transmit strobe to the UART.
REQ-010 SHALL have port uart_tx_data, output, 8: the byte to transmit.
REQ-011 SHALL have port uart_busy, input, 1: the UART transmitter is busy.
REQ-012 SHALL have port grant, output, 2: one-hot owner of the transmitter, or zero.
REQ-013 SHALL have port locked, output, 1: the owner holds a message lock.
REQ-014 SHALL have ports sent0 and sent1, output, CNT_W each: bytes sent per requester.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> SETTLE -> DRAIN -> IDLE, one-hot or binary.
REQ-016 IDLE: SHALL assert req_ready[g] = (grant==g) && req_valid[g] && !uart_busy, and nothing else.
REQ-017 An acceptance in IDLE SHALL register the byte in uart_tx_data and enter ISSUE on the next edge.
REQ-018 ISSUE SHALL drive uart_wr=1 for exactly one cycle, increment sent[g], and go to SETTLE.
REQ-019 SETTLE SHALL last exactly one cycle with uart_busy ignored, covering the UART's one-cycle busy latency, then go to DRAIN.
REQ-020 DRAIN SHALL stay until uart_busy=0, then go to IDLE.
REQ-021 Accept-to-uart_wr latency SHALL be exactly 1 cycle.
REQ-022 Back-to-back bytes SHALL have a minimum spacing of 3 cycles plus the UART busy time.
REQ-023 Grant selection SHALL happen in IDLE while unlocked: round-robin over req_valid, with priority to the requester not served last.
REQ-024 grant SHALL be 0 when unlocked and no request is pending.
REQ-025 grant SHALL update combinationally from the registered last-served pointer.
REQ-026 Accepting a byte with req_last=0 SHALL set locked=1 and hold grant to that requester; the other requester SHALL see req_ready=0.
REQ-027 Accepting a byte with req_last=1 SHALL clear locked when the FSM returns to IDLE and advance the round-robin pointer.
REQ-028 Lock timeout: while locked in IDLE with req_valid[g]=0, a counter SHALL count cycles; at LOCK_TIMEOUT it SHALL clear locked and advance the pointer.
REQ-029 The lock-timeout counter SHALL clear on any acceptance.
REQ-030 sent0 and sent1 SHALL wrap modulo 2^CNT_W with no saturation.
REQ-031 Simultaneous req_valid in IDLE with the pointer at requester 1: requester 0 SHALL be granted, and vice versa.
REQ-032 req_valid withdrawn before acceptance SHALL NOT be treated as an error; nothing is latched.
REQ-033 uart_busy=1 in IDLE (UART start-up dummy) SHALL block acceptance until it drops.
REQ-034 A requester SHALL NOT be accepted twice for the same ready pulse; req_ready is 0 outside IDLE.

Reset
REQ-035 Reset SHALL force: FSM=IDLE, uart_wr=0, uart_tx_data=0, locked=0, grant pointer=requester 0, timeout counter=0, sent0=sent1=0.
REQ-036 Outputs under reset SHALL be: req_ready=0, grant=0 until a request is seen.
REQ-037 Reset asserted mid-operation, in ISSUE/SETTLE/DRAIN, SHALL abandon the byte without a further uart_wr pulse.
REQ-038 Reset assertion SHALL act asynchronously; deassertion SHALL be sampled on clk.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, NREQ=2 and the default LOCK_TIMEOUT value.
REQ-040 Round-robin selection SHALL be a sub-module rr_pick2: inputs req[1:0] and last-served; output one-hot grant.
REQ-041 The block SHALL connect directly to the existing buffered UART's wr/tx_data/busy ports with no glue logic.

Verification
REQ-042 Single byte: req_valid0=1, data0=0x41, last=1 with busy=0 -> req_ready0 for 1 cycle, uart_wr 1 cycle later with tx_data=0x41, sent0=1.
REQ-043 Contention: both valid and last every byte, pointer at 0 -> output order strictly req1, req0, req1, req0 over 4 bytes.
REQ-044 Lock: req0 sends "AB" (last only on B) while req1 is valid -> UART sees A, B, then req1's byte; locked is high between A and B.
REQ-045 Timeout: with LOCK_TIMEOUT=8, req0 sends a last=0 byte then drops valid -> locked clears after exactly 8 IDLE cycles and req1 is then granted.
REQ-046 Busy spacing: model the UART with busy rising 1 cycle after wr and lasting 20 cycles -> no uart_wr while busy, and no byte lost over 10 bytes.
REQ-047 Reset mid-DRAIN, then release -> no uart_wr pulse, all counters 0, and a fresh request is served normally.
